// File: rtl/micro_counter_pkg.sv
// Shared types and helpers for the micro-tile pattern counter.
// Holds the mode encoding, LFSR tap table and Gray conversion.
package micro_counter_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_GRAY = 2'b10,
        MODE_LFSR = 2'b11
    } mode_e;

    // Galois right-shift masks; bit (t-1) set for each feedback tap t.
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0E08;
            13:      return 16'h1C80;
            14:      return 16'h3802;
            15:      return 16'h6000;
            16:      return 16'hB400;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] to_gray(input logic [15:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/micro_pattern_counter_prescaler.sv
// Enable-gated prescaler: ticks every div+1 enabled cycles.
// A clear restarts the interval from zero.
module micro_prescaler
    import micro_counter_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [W-1:0] div,
    input  logic         clear,
    output logic         tick
);

    logic [W-1:0] pcnt;

    // >= lets a lowered div take effect on the next enabled cycle
    assign tick = enable && (pcnt >= div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (clear || tick) begin
            pcnt <= '0;
        end else if (enable) begin
            pcnt <= pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/micro_pattern_counter.sv
// Bring-up / pad-test pattern generator for the micro tile:
// up, down, Gray or LFSR pattern with prescaler, load and bypass.
module micro_pattern_counter
    import micro_counter_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int PRESCALE_W  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] div,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  bypass,
    input  logic [WIDTH-1:0]      bypass_val,
    output logic [WIDTH-1:0]      pat_out,
    output logic                  wrap
);

    if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
        $error("micro_pattern_counter: WIDTH must be 4..16");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("micro_pattern_counter: SYNC_STAGES must be >= 2");
    end

    localparam logic [15:0]      TAPS16 = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS   = TAPS16[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    logic [SYNC_STAGES-1:0] rst_sync;
    logic                   rst_i;
    mode_e                  md;
    logic                   tick;
    logic [WIDTH-1:0]       cnt;
    logic [WIDTH-1:0]       lfsr;
    logic [WIDTH-1:0]       lfsr_step;
    logic [WIDTH-1:0]       value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync <= '1;
        end else begin
            rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign rst_i = rst_sync[SYNC_STAGES-1];
    assign md    = mode_e'(mode);

    micro_prescaler #(
        .W (PRESCALE_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst_i),
        .enable (enable),
        .div    (div),
        .clear  (load),
        .tick   (tick)
    );

    assign lfsr_step = {1'b0, lfsr[WIDTH-1:1]}
                     ^ (lfsr[0] ? TAPS : '0);

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            cnt  <= '0;
            lfsr <= ONE;
            wrap <= 1'b0;
        end else if (load) begin
            cnt  <= load_val;
            lfsr <= (load_val == '0) ? ONE : load_val;
            wrap <= 1'b0;
        end else if (tick) begin
            case (md)
                MODE_UP, MODE_GRAY: begin
                    cnt  <= cnt + 1'b1;
                    wrap <= &cnt;
                end
                MODE_DOWN: begin
                    cnt  <= cnt - 1'b1;
                    wrap <= (cnt == '0);
                end
                MODE_LFSR: begin
                    lfsr <= lfsr_step;
                    wrap <= (lfsr_step == ONE);
                end
                default: wrap <= 1'b0;
            endcase
        end else begin
            wrap <= 1'b0;
        end
    end

    always_comb begin
        value = cnt;
        case (md)
            MODE_GRAY: value = WIDTH'(to_gray(16'(cnt)));
            MODE_LFSR: value = lfsr;
            default:   value = cnt;
        endcase
    end

    // Raw rst so the pads see bypass_val the instant reset asserts
    assign pat_out = (rst || bypass) ? bypass_val : value;

endmodule

// File: tb/tb_micro_pattern_counter.sv
// Self-checking bench for micro_pattern_counter (WIDTH=8).
// Sequence-position LFSR model plus directed literal checks.
module tb_micro_pattern_counter;

    localparam int W  = 8;
    localparam int PW = 4;
    localparam int SS = 2;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic [1:0]    mode       = 2'b00;
    logic          enable     = 1'b0;
    logic [PW-1:0] div        = '0;
    logic          load       = 1'b0;
    logic [W-1:0]  load_val   = '0;
    logic          bypass     = 1'b0;
    logic [W-1:0]  bypass_val = 8'hA5;
    logic [W-1:0]  pat_out;
    logic          wrap;

    int n_tests = 0;
    int n_fail  = 0;

    int seq [255];
    int pos_of [256];

    int m_sync = 0;
    int m_cnt  = 0;
    int m_lpos = 0;
    int m_pc   = 0;
    bit m_wrap = 1'b0;
    bit m_tick;

    always #5 clk = ~clk;

    micro_pattern_counter #(
        .WIDTH       (W),
        .PRESCALE_W  (PW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .enable     (enable),
        .div        (div),
        .load       (load),
        .load_val   (load_val),
        .bypass     (bypass),
        .bypass_val (bypass_val),
        .pat_out    (pat_out),
        .wrap       (wrap)
    );

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int gstep(input int v);
        int n;
        n = v >> 1;
        if ((v & 1) != 0) n = n ^ 'hB8;
        return n;
    endfunction

    function automatic int exp_pat();
        if (rst || bypass) return int'(bypass_val);
        case (mode)
            2'b00, 2'b01: return m_cnt;
            2'b10:        return m_cnt ^ (m_cnt >> 1);
            default:      return seq[m_lpos];
        endcase
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Behavioural model: counters as modular integers, LFSR as a
    // position in its precomputed maximal-length sequence.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_sync = 0;
            m_cnt  = 0;
            m_lpos = 0;
            m_pc   = 0;
            m_wrap = 1'b0;
        end else if (m_sync < SS) begin
            m_sync++;
        end else begin
            m_tick = enable && (m_pc >= int'(div));
            m_wrap = 1'b0;
            if (load) begin
                m_cnt  = int'(load_val);
                m_lpos = (load_val == 0) ? 0 : pos_of[load_val];
                m_pc   = 0;
            end else if (m_tick) begin
                m_pc = 0;
                case (mode)
                    2'b00, 2'b10: begin
                        m_cnt  = (m_cnt + 1) % 256;
                        m_wrap = (m_cnt == 0);
                    end
                    2'b01: begin
                        m_cnt  = (m_cnt + 255) % 256;
                        m_wrap = (m_cnt == 255);
                    end
                    default: begin
                        m_lpos = (m_lpos + 1) % 255;
                        m_wrap = (m_lpos == 0);
                    end
                endcase
            end else if (enable) begin
                m_pc++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("cyc_pat_out", 32'(pat_out), exp_pat());
        check("cyc_wrap", 32'(wrap), 32'(m_wrap));
    end

    initial begin
        int v;
        int ndist;
        int nwraps;
        bit seen [256];
        int lit [5];

        v = 1;
        for (int i = 0; i < 256; i++) pos_of[i] = -1;
        for (int i = 0; i < 255; i++) begin
            seq[i]    = v;
            pos_of[v] = i;
            v         = gstep(v);
        end
        lit[0] = 'hB8;
        lit[1] = 'h5C;
        lit[2] = 'h2E;
        lit[3] = 'h17;
        lit[4] = 'hB3;

        #1 check("rst_passthru", 32'(pat_out), 32'hA5);
        cyc(2);
        rst = 1'b0; mode = 2'b00; div = 0; enable = 1'b1;
        cyc(1); check("sync_0a", 32'(pat_out), 32'h00);
        cyc(1); check("sync_0b", 32'(pat_out), 32'h00);
        cyc(1); check("up_01", 32'(pat_out), 32'h01);
        cyc(1); check("up_02", 32'(pat_out), 32'h02);
        cyc(1); check("up_03", 32'(pat_out), 32'h03);

        div = 3; load = 1'b1; load_val = 8'hFE;
        cyc(1); load = 1'b0;
        check("load_fe", 32'(pat_out), 32'hFE);
        cyc(4); check("up_ff", 32'(pat_out), 32'hFF);
        check("up_ff_nowrap", 32'(wrap), 32'h0);
        cyc(4); check("up_00", 32'(pat_out), 32'h00);
        check("up_wrap", 32'(wrap), 32'h1);
        cyc(1); check("up_wrap_drop", 32'(wrap), 32'h0);

        mode = 2'b01; div = 0; load = 1'b1; load_val = 8'h02;
        cyc(1); load = 1'b0;
        check("dn_02", 32'(pat_out), 32'h02);
        cyc(1); check("dn_01", 32'(pat_out), 32'h01);
        cyc(1); check("dn_00", 32'(pat_out), 32'h00);
        check("dn_00_nowrap", 32'(wrap), 32'h0);
        cyc(1); check("dn_ff", 32'(pat_out), 32'hFF);
        check("dn_wrap", 32'(wrap), 32'h1);
        enable = 1'b0;
        cyc(3); check("dn_hold", 32'(pat_out), 32'hFF);
        check("dn_hold_wrap", 32'(wrap), 32'h0);

        mode = 2'b10; load = 1'b1; load_val = 8'h05;
        cyc(1); load = 1'b0;
        check("gray_07", 32'(pat_out), 32'h07);
        enable = 1'b1;
        cyc(1); check("gray_05", 32'(pat_out), 32'h05);
        enable = 1'b0; mode = 2'b00;
        #1 check("gray_to_up", 32'(pat_out), 32'h06);
        bypass = 1'b1; bypass_val = 8'h5A;
        #1 check("bypass", 32'(pat_out), 32'h5A);
        bypass = 1'b0;
        #1 check("bypass_off", 32'(pat_out), 32'h06);

        enable = 1'b1; div = 3;
        cyc(2); div = 1;
        cyc(1); check("div_lower", 32'(pat_out), 32'h07);

        rst = 1'b1;
        cyc(1);
        mode = 2'b11; div = 0; enable = 1'b1; rst = 1'b0;
        cyc(2); check("lfsr_rst", 32'(pat_out), 32'h01);
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        ndist  = 0;
        nwraps = 0;
        for (int i = 0; i < 255; i++) begin
            cyc(1);
            v = int'(pat_out);
            if (i < 5) check("lfsr_lit", 32'(v), 32'(lit[i]));
            if (v != 0 && !seen[v]) ndist++;
            seen[v] = 1'b1;
            if (wrap) nwraps++;
        end
        check("lfsr_period", 32'(v), 32'h01);
        check("lfsr_distinct", 32'(ndist), 32'd255);
        check("lfsr_wraps", 32'(nwraps), 32'd1);
        load = 1'b1; load_val = 8'h00;
        cyc(1); load = 1'b0;
        check("lfsr_load0", 32'(pat_out), 32'h01);
        check("lfsr_load0_wrap", 32'(wrap), 32'h0);

        mode = 2'b00; load = 1'b1; load_val = 8'hFF;
        cyc(1); check("prio_pre", 32'(pat_out), 32'hFF);
        load_val = 8'h40;
        cyc(1); load = 1'b0;
        check("prio_load", 32'(pat_out), 32'h40);
        check("prio_nowrap", 32'(wrap), 32'h0);

        div = 3; load = 1'b1; load_val = 8'h10;
        cyc(1); load = 1'b0;
        cyc(2);
        bypass_val = 8'h3C; rst = 1'b1;
        #1 check("rst_mid", 32'(pat_out), 32'h3C);
        check("rst_mid_wrap", 32'(wrap), 32'h0);
        cyc(2);
        rst = 1'b0; bypass_val = 8'hA5;
        cyc(5); check("restart_hold", 32'(pat_out), 32'h00);
        cyc(1); check("restart_01", 32'(pat_out), 32'h01);
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
